// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs CNN layer blocks in order with watchdog, abort and per-layer cycle counters
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF,
  parameter int LAYER_IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic [NUM_LAYERS-1:0]  layer_enable,
  output logic                   busy,
  output logic                   cnn_done,
  output logic                   error,
  output logic [LAYER_IDX_W-1:0] err_layer,
  input  logic [LAYER_IDX_W-1:0] perf_sel,
  output logic [CNT_W-1:0]       perf_cycles
);
  typedef enum logic [2:0] {IDLE, RUN, GAP, DONE, ERROR} state_t;
  state_t state, state_nxt;
  logic [LAYER_IDX_W-1:0] cur;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CNT_W-1:0] perf [NUM_LAYERS];
  logic go, run_ok, hit, tout, last;
  // Next-state decode; abort outranks done, done outranks the watchdog
  always_comb begin
    cnt_inc = cnt + 1'b1;
    go = start && (state == IDLE || state == ERROR);
    run_ok = state == RUN && !abort;
    hit = run_ok && layer_done[cur];
    tout = run_ok && !layer_done[cur] && cnt_inc == TIMEOUT_CYCLES;
    last = int'(cur) == NUM_LAYERS - 1;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go ? RUN : IDLE;
      RUN:     state_nxt = abort ? IDLE : hit ? (last ? DONE : GAP) : tout ? ERROR : RUN;
      GAP:     state_nxt = abort ? IDLE : RUN;
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = go ? RUN : ERROR;
      default: state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // Layer index, cycle counter, perf capture and error layer; the count includes the done cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= '0;
      cnt <= '0;
      err_layer <= '0;
      perf <= '{default: '0};
    end else if (go) begin
      cur <= '0;
      cnt <= '0;
      err_layer <= '0;
      perf <= '{default: '0};
    end else if (run_ok) begin
      cnt <= cnt_inc;
      if (layer_done[cur]) perf[cur] <= cnt_inc;
      if (tout) err_layer <= cur;
    end else if (state == GAP && !abort) begin
      cur <= cur + 1'b1;
      cnt <= '0;
    end
  end
  genvar i;
  for (i = 0; i < NUM_LAYERS; i++) begin : g_en
    assign layer_enable[i] = state == RUN && int'(cur) == i;
  end
  assign busy = state inside {RUN, GAP, DONE};
  assign cnn_done = state == DONE;
  assign error = state == ERROR;
  assign perf_cycles = int'(perf_sel) < NUM_LAYERS ? perf[perf_sel] : '0;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: plan-driven random runs checked cycle by cycle against a timeline model
module tb_cnn_layer_sequencer;
  localparam int N = 3;
  localparam int T = 10;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [2:0] layer_done = '0;
  logic [2:0] layer_enable;
  logic busy, cnn_done, error;
  logic [1:0] err_layer;
  logic [1:0] perf_sel = '0;
  logic [15:0] perf_cycles;
  int n_chk = 0, n_pass = 0;
  logic [2:0] q_en[$], q_done[$];
  bit q_cd[$], q_ab[$], q_st[$];
  bit exp_err;
  int exp_el;
  int exp_perf[3];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.NUM_LAYERS(N), .CNT_W(16), .TIMEOUT_CYCLES(16'd10), .LAYER_IDX_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .layer_done(layer_done),
    .layer_enable(layer_enable), .busy(busy), .cnn_done(cnn_done), .error(error),
    .err_layer(err_layer), .perf_sel(perf_sel), .perf_cycles(perf_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected timeline: each layer runs lat cycles (or T on no-done), one gap between layers, one done cycle
  task automatic build(input int l0, input int l1, input int l2, input int ab_l, input int ab_c,
                       input bit ab_d, input bit noise);
    int lat[3];
    int run, h;
    bit ended;
    logic [2:0] base[$];
    lat = '{l0, l1, l2};
    q_en.delete(); q_done.delete(); q_cd.delete(); q_ab.delete(); q_st.delete();
    exp_err = 0; exp_el = 0; exp_perf = '{0, 0, 0}; ended = 0;
    for (int k = 0; k < N && !ended; k++) begin
      if (k > 0) begin
        q_en.push_back(3'b0); q_done.push_back(3'b0); q_cd.push_back(0); q_ab.push_back(0);
      end
      run = (lat[k] < 1 || lat[k] > T) ? T : lat[k];
      for (int c = 1; c <= run && !ended; c++) begin
        q_en.push_back(3'(1 << k)); q_cd.push_back(0);
        if (ab_l == k && ab_c == c) begin
          q_ab.push_back(1); q_done.push_back(ab_d ? 3'(1 << k) : 3'b0); ended = 1;
        end else begin
          q_ab.push_back(0); q_done.push_back(c == lat[k] ? 3'(1 << k) : 3'b0);
          if (c == lat[k]) exp_perf[k] = lat[k];
        end
      end
      if (!ended && run != lat[k]) begin exp_err = 1; exp_el = k; ended = 1; end
    end
    if (!ended) begin
      q_en.push_back(3'b0); q_done.push_back(3'b0); q_cd.push_back(1); q_ab.push_back(0);
    end
    for (int i = 0; i < q_en.size(); i++) q_st.push_back(noise && $urandom % 4 == 0);
    if (noise) begin
      base = q_done;
      for (int i = 0; i < q_en.size(); i++) begin
        if (q_en[i] == 3'b001 && $urandom % 3 == 0) q_done[i] = q_done[i] | 3'b100;
        if (base[i] != 0 && !q_ab[i]) begin
          h = $urandom_range(0, 3);
          for (int j = 1; j <= h; j++) if (i + j < q_done.size()) q_done[i + j] = q_done[i + j] | base[i];
        end
      end
    end
  endtask

  task automatic run_plan(input string name, input int limit);
    @(negedge clk); start = 1; abort = 0; layer_done = '0;
    for (int i = 0; i < q_en.size() && i < limit; i++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d enable", name, i), layer_enable, q_en[i]);
      chk($sformatf("%s c%0d busy", name, i), busy, 1);
      chk($sformatf("%s c%0d cnn_done", name, i), cnn_done, q_cd[i]);
      chk($sformatf("%s c%0d error", name, i), error, 0);
      chk($sformatf("%s c%0d err_layer", name, i), err_layer, 0);
      start = q_st[i]; layer_done = q_done[i]; abort = q_ab[i];
    end
    if (limit < q_en.size()) return;
    @(negedge clk); start = 0; layer_done = '0; abort = 0;
    chk($sformatf("%s end enable", name), layer_enable, 0);
    chk($sformatf("%s end busy", name), busy, 0);
    chk($sformatf("%s end cnn_done", name), cnn_done, 0);
    chk($sformatf("%s end error", name), error, exp_err);
    chk($sformatf("%s end err_layer", name), err_layer, exp_el);
    for (int s = 0; s < 4; s++) begin
      perf_sel = 2'(s); #1;
      chk($sformatf("%s perf%0d", name, s), perf_cycles, s < N ? exp_perf[s] : 0);
    end
  endtask

  initial begin
    int l[3];
    int al, ac, run;
    #12;
    chk("reset enable", layer_enable, 0);
    chk("reset busy", busy, 0);
    chk("reset cnn_done", cnn_done, 0);
    chk("reset error", error, 0);
    chk("reset err_layer", err_layer, 0);
    chk("reset perf0", perf_cycles, 0);
    @(negedge clk); reset_n = 1;
    build(5, 3, 7, -1, 0, 0, 0); run_plan("nominal", 1000);
    build(5, 0, 7, -1, 0, 0, 0); run_plan("watchdog", 1000);
    build(5, 3, 7, -1, 0, 0, 0); run_plan("after_err", 1000);
    build(5, 3, 10, -1, 0, 0, 0); run_plan("boundary", 1000);
    build(5, 3, 7, 1, 2, 0, 0); run_plan("abort_l1c2", 1000);
    build(5, 3, 7, 1, 3, 1, 0); run_plan("abort_vs_done", 1000);
    build(5, 3, 7, -1, 0, 0, 1); run_plan("spurious", 1000);
    build(5, 3, 7, -1, 0, 0, 0); run_plan("pre_reset", 8);
    #2 reset_n = 0;
    #1;
    perf_sel = 2'd0;
    #0;
    chk("async_reset enable", layer_enable, 0);
    chk("async_reset busy", busy, 0);
    chk("async_reset cnn_done", cnn_done, 0);
    chk("async_reset error", error, 0);
    chk("async_reset perf0", perf_cycles, 0);
    start = 0; abort = 0; layer_done = '0;
    @(negedge clk); reset_n = 1;
    build(5, 3, 7, -1, 0, 0, 0); run_plan("post_reset", 1000);
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) l[k] = ($urandom % 5 == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(1, T));
      al = -1; ac = 0;
      if ($urandom % 4 == 0) begin
        al = $urandom_range(0, N - 1);
        run = (l[al] < 1 || l[al] > T) ? T : l[al];
        ac = $urandom_range(1, run);
      end
      build(l[0], l[1], l[2], al, ac, 1'($urandom % 2), 1);
      run_plan($sformatf("rand%0d", r), 1000);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
